rule110_host_ctrl: RTL and testbench

RULE110_HOST_CTRL -- requirements
Module: rule110_host_ctrl

---
 rtl/rule110_host_pkg.sv | 26 ++
 rtl/rule110_host_ctrl_if.sv | 31 +++
 rtl/rule110_host_ctrl.sv | 162 ++++++++++++++++
 tb/tb_rule110_host_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rule110_host_pkg.sv
// Shared definitions for the rule-110 automaton host controller.
// Holds the command opcodes, the controller FSM state encoding and the
// default geometry of the attached automaton (block count, address width).
package rule110_host_pkg;

    localparam int NUM_BLOCKS_DEF = 29;
    localparam int ADDR_BITS_DEF  = 6;
    localparam int CMD_ARG_W      = 16;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_RUN  = 2'd1,
        OP_DUMP = 2'd2,
        OP_RSVD = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_WAIT = 3'd1,
        ST_LOAD_WR   = 3'd2,
        ST_RUN       = 3'd3,
        ST_DUMP_ADDR = 3'd4,
        ST_DUMP_OUT  = 3'd5
    } state_e;

endpackage

// File: rtl/rule110_host_ctrl_if.sv
// Host-side bus of the rule-110 controller: the command handshake, the
// byte stream into the automaton (LOAD) and the byte stream out (DUMP).
//   cmd_valid/cmd_ready, cmd_op[1:0], cmd_arg[15:0] : command channel
//   s_data[7:0]/s_valid/s_ready                     : LOAD byte stream
//   m_data[7:0]/m_valid/m_ready                     : DUMP byte stream
// master = host side, slave = controller side.
interface rule110_host_ctrl_if;
    import rule110_host_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [CMD_ARG_W-1:0] cmd_arg;
    logic [7:0]           s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic [7:0]           m_data;
    logic                 m_valid;
    logic                 m_ready;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, s_data, s_valid, m_ready,
        input  cmd_ready, s_ready, m_data, m_valid
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, s_data, s_valid, m_ready,
        output cmd_ready, s_ready, m_data, m_valid
    );

endinterface

// File: rtl/rule110_host_ctrl.sv
// Host controller for a block-addressed rule-110 cellular automaton.
// Accepts LOAD (stream bytes into the automaton blocks), RUN (release the
// halt for N generations) and DUMP (stream the blocks back out) commands.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   host (slave)        : command / LOAD stream / DUMP stream bus
//   ca_data, ca_we_n    : block write data and active-low write strobe
//   ca_halt_n           : active-low halt; one generation per cycle when high
//   ca_addr             : block address
//   ca_q                : automaton read data (combinational from ca_addr)
//   busy                : high whenever the controller is not idle
module rule110_host_ctrl
    import rule110_host_pkg::*;
#(
    parameter int NUM_BLOCKS = NUM_BLOCKS_DEF,
    parameter int ADDR_BITS  = ADDR_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    rule110_host_ctrl_if.slave   host,
    output logic [7:0]           ca_data,
    output logic                 ca_we_n,
    output logic                 ca_halt_n,
    output logic [ADDR_BITS-1:0] ca_addr,
    input  logic [7:0]           ca_q,
    output logic                 busy
);

    localparam logic [ADDR_BITS-1:0] LAST_BLK = ADDR_BITS'(NUM_BLOCKS - 1);

    state_e                 state;
    state_e                 next_state;
    logic [ADDR_BITS-1:0]   blk;
    logic [CMD_ARG_W-1:0]   gen;
    logic                   cmd_accept;
    logic                   last_blk;
    logic                   run_done;

    assign cmd_accept = host.cmd_valid && (state == ST_IDLE);
    assign last_blk   = (blk == LAST_BLK);
    // The final halt-released cycle is the one where the counter reads 1;
    // a zero count leaves RUN straight away.
    assign run_done   = (gen <= CMD_ARG_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state     = state;
        host.cmd_ready = 1'b0;
        host.s_ready   = 1'b0;
        busy           = 1'b1;
        case (state)
            ST_IDLE: begin
                host.cmd_ready = 1'b1;
                busy           = 1'b0;
                if (host.cmd_valid) begin
                    case (op_e'(host.cmd_op))
                        OP_LOAD: next_state = ST_LOAD_WAIT;
                        OP_RUN:  next_state = ST_RUN;
                        OP_DUMP: next_state = ST_DUMP_ADDR;
                        default: next_state = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD_WAIT: begin
                host.s_ready = 1'b1;
                if (host.s_valid) next_state = ST_LOAD_WR;
            end
            ST_LOAD_WR:   next_state = last_blk ? ST_IDLE : ST_LOAD_WAIT;
            ST_RUN:       if (run_done) next_state = ST_IDLE;
            ST_DUMP_ADDR: next_state = ST_DUMP_OUT;
            ST_DUMP_OUT: begin
                if (host.m_ready) next_state = last_blk ? ST_IDLE : ST_DUMP_ADDR;
            end
            default:      next_state = ST_IDLE;
        endcase
    end

    // Every automaton-facing pin and the DUMP byte come straight from these
    // flops, so nothing on the host side can reach the ca_* pins combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk          <= '0;
            gen          <= '0;
            ca_data      <= '0;
            ca_we_n      <= 1'b1;
            ca_halt_n    <= 1'b0;
            ca_addr      <= '0;
            host.m_data  <= '0;
            host.m_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_accept) begin
                        case (op_e'(host.cmd_op))
                            OP_LOAD: blk <= '0;
                            OP_RUN: begin
                                gen       <= host.cmd_arg;
                                ca_halt_n <= (host.cmd_arg != '0);
                            end
                            OP_DUMP: begin
                                blk     <= '0;
                                ca_addr <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_LOAD_WAIT: begin
                    if (host.s_valid) begin
                        ca_data <= host.s_data;
                        ca_addr <= blk;
                        ca_we_n <= 1'b0;
                    end
                end
                ST_LOAD_WR: begin
                    ca_we_n <= 1'b1;
                    if (last_blk) begin
                        blk     <= '0;
                        ca_addr <= '0;
                        ca_data <= '0;
                    end else begin
                        blk <= blk + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (run_done) begin
                        gen       <= '0;
                        ca_halt_n <= 1'b0;
                    end else begin
                        gen <= gen - 1'b1;
                    end
                end
                ST_DUMP_ADDR: begin
                    // ca_addr has been stable for a full cycle, so ca_q is settled.
                    host.m_data  <= ca_q;
                    host.m_valid <= 1'b1;
                end
                ST_DUMP_OUT: begin
                    if (host.m_ready) begin
                        host.m_valid <= 1'b0;
                        if (last_blk) begin
                            blk     <= '0;
                            ca_addr <= '0;
                        end else begin
                            blk     <= blk + 1'b1;
                            ca_addr <= blk + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rule110_host_ctrl.sv
// Bench for rule110_host_ctrl: a behavioural 232-cell wrap-around rule-110
// automaton hangs off the ca_* pins; command vectors and hand-built
// sequences drive the host bus and compare against hand-computed values.
module tb_rule110_host_ctrl;
    import rule110_host_pkg::*;

    localparam int NB = 29;
    localparam int NC = NB * 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ca_data;
    logic       ca_we_n;
    logic       ca_halt_n;
    logic [5:0] ca_addr;
    logic [7:0] ca_q;
    logic       busy;

    rule110_host_ctrl_if hif();

    rule110_host_ctrl #(.NUM_BLOCKS(NB), .ADDR_BITS(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .host     (hif.slave),
        .ca_data  (ca_data),
        .ca_we_n  (ca_we_n),
        .ca_halt_n(ca_halt_n),
        .ca_addr  (ca_addr),
        .ca_q     (ca_q),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural automaton ----------------
    // Cell i = block*8 + bit; its left neighbour is i+1, right is i-1.
    logic [NC-1:0] cells = '0;
    logic [NC-1:0] nxt_view;

    function automatic logic [NC-1:0] next_gen(input logic [NC-1:0] c);
        logic [NC-1:0] n;
        logic l, m, r;
        for (int i = 0; i < NC; i++) begin
            l = c[(i + 1) % NC];
            m = c[i];
            r = c[(i + NC - 1) % NC];
            n[i] = (m | r) & ~(l & m & r);
        end
        return n;
    endfunction

    always_comb begin
        nxt_view = next_gen(cells);
        ca_q = 8'h00;
        if (int'(ca_addr) < NB) ca_q = nxt_view[int'(ca_addr) * 8 +: 8];
    end

    always @(posedge clk) begin
        if (!ca_we_n) begin
            if (int'(ca_addr) < NB) cells[int'(ca_addr) * 8 +: 8] <= ca_data;
        end else if (ca_halt_n) begin
            cells <= next_gen(cells);
        end
    end

    // ---------------- pin monitor ----------------
    int         we_pulses = 0;
    int         we_double = 0;
    int         halt_cycles = 0;
    int         halt_rises = 0;
    int         overlap = 0;
    logic       prev_we_n = 1'b1;
    logic       prev_halt_n = 1'b0;
    logic [5:0] wr_addr_log [0:63];

    always @(posedge clk) begin
        prev_we_n   <= ca_we_n;
        prev_halt_n <= ca_halt_n;
        if (!ca_we_n) begin
            we_pulses <= we_pulses + 1;
            wr_addr_log[we_pulses[5:0]] <= ca_addr;
            if (!prev_we_n) we_double <= we_double + 1;
        end
        if (ca_halt_n) begin
            halt_cycles <= halt_cycles + 1;
            if (!prev_halt_n) halt_rises <= halt_rises + 1;
        end
        if (!ca_we_n && ca_halt_n) overlap <= overlap + 1;
    end

    // ---------------- checking helpers ----------------
    int n_compared = 0;
    int n_failed = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [15:0] arg);
        check("cmd_ready_idle", 32'(hif.cmd_ready), 32'd1);
        hif.cmd_valid = 1'b1;
        hif.cmd_op    = op;
        hif.cmd_arg   = arg;
        tick();
        hif.cmd_valid = 1'b0;
        hif.cmd_arg   = '0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    logic [7:0] load_bytes [NB];
    logic [7:0] dump_buf   [NB];
    logic [7:0] exp_dump   [NB];

    task automatic feed_bytes(input int count);
        for (int i = 0; i < count; i++) begin
            int n = 0;
            hif.s_data  = load_bytes[i];
            hif.s_valid = 1'b1;
            while (!hif.s_ready && n < 20) begin
                tick();
                n++;
            end
            tick();
            hif.s_valid = 1'b0;
        end
    endtask

    task automatic do_load();
        int w0 = we_pulses;
        send_cmd(OP_LOAD, 16'd0);
        feed_bytes(NB);
        wait_idle(10, "load_idle");
        tick();
        check("load_we_pulses", 32'(we_pulses - w0), 32'(NB));
        check("load_we_single", 32'(we_double), 32'd0);
        for (int i = 0; i < NB; i++) begin
            check("load_addr", 32'(wr_addr_log[6'(w0 + i)]), 32'(i));
            check("load_cells", 32'(cells[i * 8 +: 8]), 32'(load_bytes[i]));
        end
    endtask

    // stall_at < 0: no back-pressure; otherwise hold m_ready low for 10
    // cycles on that byte.
    task automatic do_dump(input int stall_at);
        int n = 0;
        int guard = 0;
        logic [7:0] held = 8'h00;
        logic stalled = 1'b0;
        hif.m_ready = 1'b1;
        send_cmd(OP_DUMP, 16'd0);
        while (n < NB && guard < 2000) begin
            if (hif.m_valid) begin
                if (n == stall_at && !stalled) begin
                    hif.m_ready = 1'b0;
                    held = hif.m_data;
                    stalled = 1'b1;
                    for (int k = 0; k < 9; k++) begin
                        tick();
                        check("stall_m_valid", 32'(hif.m_valid), 32'd1);
                        check("stall_m_data", 32'(hif.m_data), 32'(held));
                    end
                end else begin
                    hif.m_ready = 1'b1;
                    dump_buf[n] = hif.m_data;
                    n++;
                end
            end
            tick();
            guard++;
        end
        hif.m_ready = 1'b1;
        check("dump_count", 32'(n), 32'(NB));
        if (stall_at >= 0) check("stall_byte_kept", 32'(dump_buf[stall_at]), 32'(held));
        wait_idle(10, "dump_idle");
        check("dump_m_valid_after", 32'(hif.m_valid), 32'd0);
        for (int i = 0; i < NB; i++) check("dump_byte", 32'(dump_buf[i]), 32'(exp_dump[i]));
    endtask

    task automatic set_exp_dump(input logic [7:0] b0);
        for (int i = 0; i < NB; i++) exp_dump[i] = 8'h00;
        exp_dump[0] = b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] arg;
        int          exp_halt;
        int          exp_we;
    } cmd_vec_t;

    cmd_vec_t vecs [4];

    initial begin
        int h0, r0, w0;

        vecs[0] = '{op: OP_RUN,  arg: 16'd0, exp_halt: 0, exp_we: 0};
        vecs[1] = '{op: OP_RSVD, arg: 16'd7, exp_halt: 0, exp_we: 0};
        vecs[2] = '{op: OP_RUN,  arg: 16'd2, exp_halt: 2, exp_we: 0};
        vecs[3] = '{op: OP_RUN,  arg: 16'd1, exp_halt: 1, exp_we: 0};

        hif.cmd_valid = 1'b0;
        hif.cmd_op    = 2'd0;
        hif.cmd_arg   = '0;
        hif.s_data    = '0;
        hif.s_valid   = 1'b0;
        hif.m_ready   = 1'b1;

        // reset state
        tick();
        tick();
        check("rst_cmd_ready", 32'(hif.cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we_n", 32'(ca_we_n), 32'd1);
        check("rst_halt_n", 32'(ca_halt_n), 32'd0);
        check("rst_addr", 32'(ca_addr), 32'd0);
        check("rst_data", 32'(ca_data), 32'd0);
        check("rst_m_valid", 32'(hif.m_valid), 32'd0);
        check("rst_m_data", 32'(hif.m_data), 32'd0);
        check("rst_s_ready", 32'(hif.s_ready), 32'd0);
        reset = 1'b0;
        tick();

        // LOAD single live cell at cell 0
        for (int i = 0; i < NB; i++) load_bytes[i] = 8'h00;
        load_bytes[0] = 8'h01;
        do_load();

        // DUMP shows the T+1 view: cells 0 and 1 alive
        set_exp_dump(8'h03);
        do_dump(-1);

        // RUN 5: generation 5 of a single cell is cells {0,4,5}
        h0 = halt_cycles;
        r0 = halt_rises;
        send_cmd(OP_RUN, 16'd5);
        wait_idle(20, "run5_idle");
        tick();
        check("run5_halt_cycles", 32'(halt_cycles - h0), 32'd5);
        check("run5_halt_rises", 32'(halt_rises - r0), 32'd1);
        check("run5_block0", 32'(cells[7:0]), 32'h31);
        check("run5_block1", 32'(cells[15:8]), 32'h00);

        // DUMP with back-pressure on byte 3; generation 6 is {0,1,4,5,6}
        set_exp_dump(8'h73);
        do_dump(3);

        // command vectors: RUN 0, reserved opcode, short RUNs
        foreach (vecs[v]) begin
            h0 = halt_cycles;
            r0 = halt_rises;
            w0 = we_pulses;
            send_cmd(vecs[v].op, vecs[v].arg);
            wait_idle(50, "vec_idle");
            tick();
            check("vec_halt_cycles", 32'(halt_cycles - h0), 32'(vecs[v].exp_halt));
            check("vec_halt_rises", 32'(halt_rises - r0), (vecs[v].exp_halt > 0) ? 32'd1 : 32'd0);
            check("vec_we_pulses", 32'(we_pulses - w0), 32'(vecs[v].exp_we));
            check("vec_halt_low", 32'(ca_halt_n), 32'd0);
        end

        // reset in the middle of a LOAD: no further write strobes
        send_cmd(OP_LOAD, 16'd0);
        feed_bytes(3);
        reset = 1'b1;
        #1;
        check("ldrst_busy", 32'(busy), 32'd0);
        check("ldrst_s_ready", 32'(hif.s_ready), 32'd0);
        check("ldrst_we_n", 32'(ca_we_n), 32'd1);
        tick();
        reset = 1'b0;
        w0 = we_pulses;
        repeat (10) tick();
        check("ldrst_no_we", 32'(we_pulses - w0), 32'd0);
        check("ldrst_idle", 32'(busy), 32'd0);

        // reset at cycle 40 of RUN 1000
        send_cmd(OP_RUN, 16'd1000);
        repeat (39) tick();
        check("runrst_halt_before", 32'(ca_halt_n), 32'd1);
        reset = 1'b1;
        #1;
        check("runrst_halt_n", 32'(ca_halt_n), 32'd0);
        check("runrst_busy", 32'(busy), 32'd0);
        check("runrst_cmd_ready", 32'(hif.cmd_ready), 32'd1);
        check("runrst_addr", 32'(ca_addr), 32'd0);
        check("runrst_m_valid", 32'(hif.m_valid), 32'd0);
        tick();
        reset = 1'b0;
        h0 = halt_cycles;
        repeat (5) tick();
        check("runrst_halt_stays", 32'(halt_cycles - h0), 32'd0);

        // normal operation afterwards
        do_load();
        set_exp_dump(8'h03);
        do_dump(-1);

        check("no_we_halt_overlap", 32'(overlap), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit, expected completion");
        $fatal(1, "timeout");
    end

endmodule
